// File: rtl/move_scheduler.sv
// move_scheduler
//   Sits between the SPI byte receiver and game_executioner in the game_clk
//   domain. SPI command bytes carrying a move are queued in a small FIFO, and
//   at most one move is released per game tick. When the queue is empty and
//   the gravity interval has expired, a gravity move is issued instead. The
//   most recent piece select is held for the executioner.
//
// Parameters
//   DEPTH          FIFO entries (power of two, 2..16)
//   GRAVITY_TICKS  ticks between gravity moves (>= 1)
//   GRAVITY_CMD    2-bit move code issued for gravity
//
// Ports
//   game_clk        in   clock, rising edge
//   reset_n         in   synchronous, active-low reset
//   cmd_byte        in   [1:0] move, [4:2] piece select, [5] move_valid, [7:6] ignored
//   cmd_strobe      in   one-cycle pulse, cmd_byte valid
//   tick            in   one-cycle game step enable
//   busy            in   executioner cannot accept a step this cycle
//   move_out        out  move code to executioner (held until the next real move)
//   move_valid_out  out  1 = real move, 0 = no-op step
//   piece_sel       out  latest piece select, 0..6 (7 is written as 0)
//   step_valid      out  one-cycle pulse, move_out/move_valid_out valid
//   fifo_count      out  current FIFO occupancy, 0..DEPTH
//   overflow        out  sticky, a move byte was dropped because the FIFO was full
//
// Configuration
//   MOVE_SCHED_DEDUP_EN  when defined, a move byte whose [1:0] equals the move
//                        at the FIFO tail (FIFO non-empty) is discarded; this
//                        discard never counts as overflow.

module move_scheduler #(
  parameter int         DEPTH         = 4,
  parameter int         GRAVITY_TICKS = 8,
  parameter logic [1:0] GRAVITY_CMD   = 2'd1
) (
  input  logic                     game_clk,
  input  logic                     reset_n,
  input  logic [7:0]               cmd_byte,
  input  logic                     cmd_strobe,
  input  logic                     tick,
  input  logic                     busy,
  output logic [1:0]               move_out,
  output logic                     move_valid_out,
  output logic [2:0]               piece_sel,
  output logic                     step_valid,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int GW = $clog2(GRAVITY_TICKS + 1);

  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [GW-1:0] GRAV_MAX = GW'(GRAVITY_TICKS);

  typedef enum logic {IDLE, ISSUE} state_t;

  state_t      state, state_nxt;
  logic [1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [GW-1:0] grav_cnt;

  logic fifo_empty, fifo_full;
  logic is_move, dup, push, pop, ovf_set;
  logic issue, real_step;
  logic       step_nxt, mvv_nxt;
  logic [1:0] move_nxt;

  // The top two command bits carry no meaning here.
  logic unused_cmd_bits;
  assign unused_cmd_bits = ^cmd_byte[7:6];

  // Gravity counter saturates at the interval instead of wrapping.
  function automatic logic [GW-1:0] sat_inc(input logic [GW-1:0] c);
    return (c >= GRAV_MAX) ? GRAV_MAX : c + GW'(1);
  endfunction

  // Piece select 7 is not a valid piece and is folded onto 0.
  function automatic logic [2:0] map_piece(input logic [2:0] s);
    return (s == 3'd7) ? 3'd0 : s;
  endfunction

  assign fifo_empty = (fifo_count == '0);
  assign fifo_full  = (fifo_count == FULL_CNT);
  assign is_move    = cmd_strobe & cmd_byte[5];
  assign issue      = (state == ISSUE) & ~busy;
  // Pop uses the pre-edge occupancy, so a byte pushed into an empty FIFO is
  // only poppable from the following cycle.
  assign pop        = issue & ~fifo_empty;

`ifdef MOVE_SCHED_DEDUP_EN
  logic [PW-1:0] tail_idx;
  assign tail_idx = wr_ptr - PW'(1);
  assign dup      = ~fifo_empty & (cmd_byte[1:0] == mem[tail_idx]);
`else
  assign dup      = 1'b0;
`endif

  // A pop in the same cycle frees the slot, so a push into a full FIFO is
  // still accepted and does not count as overflow.
  assign push    = is_move & ~dup & (~fifo_full | pop);
  assign ovf_set = is_move & ~dup & fifo_full & ~pop;

  // FSM state register
  always_ff @(posedge game_clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // FSM next state; ticks seen while in ISSUE are dropped.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (tick)  state_nxt = ISSUE;
      ISSUE:   if (!busy) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs: decide what the next step carries. move_out keeps its last
  // real move across no-op steps.
  always_comb begin
    step_nxt  = 1'b0;
    mvv_nxt   = move_valid_out;
    move_nxt  = move_out;
    real_step = 1'b0;
    if (issue) begin
      step_nxt = 1'b1;
      if (!fifo_empty) begin
        move_nxt  = mem[rd_ptr];
        mvv_nxt   = 1'b1;
        real_step = 1'b1;
      end else if (grav_cnt == GRAV_MAX) begin
        move_nxt  = GRAVITY_CMD;
        mvv_nxt   = 1'b1;
        real_step = 1'b1;
      end else begin
        mvv_nxt   = 1'b0;
      end
    end
  end

  // Step outputs, FIFO control, gravity counter, piece select, overflow
  always_ff @(posedge game_clk) begin
    if (!reset_n) begin
      step_valid     <= 1'b0;
      move_valid_out <= 1'b0;
      move_out       <= 2'd0;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      fifo_count     <= '0;
      grav_cnt       <= '0;
      piece_sel      <= 3'd0;
      overflow       <= 1'b0;
    end else begin
      step_valid     <= step_nxt;
      move_valid_out <= mvv_nxt;
      move_out       <= move_nxt;
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
      if (real_step)  grav_cnt <= '0;
      else if (tick)  grav_cnt <= sat_inc(grav_cnt);
      if (cmd_strobe) piece_sel <= map_piece(cmd_byte[4:2]);
      if (ovf_set)    overflow <= 1'b1;
    end
  end

  // FIFO storage; contents need no reset because occupancy gates every read.
  always_ff @(posedge game_clk) begin
    if (push) mem[wr_ptr] <= cmd_byte[1:0];
  end

endmodule

// File: tb/tb_move_scheduler.sv
module tb_move_scheduler;

  localparam int         DEPTH = 4;
  localparam int         GT    = 3;
  localparam logic [1:0] GCMD  = 2'd1;

  logic       game_clk = 1'b0;
  logic       reset_n  = 1'b0;
  logic [7:0] cmd_byte = 8'h00;
  logic       cmd_strobe = 1'b0;
  logic       tick = 1'b0;
  logic       busy = 1'b0;
  logic [1:0] move_out;
  logic       move_valid_out;
  logic [2:0] piece_sel;
  logic       step_valid;
  logic [$clog2(DEPTH):0] fifo_count;
  logic       overflow;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [1:0] mq[$];
  int         m_grav;
  bit         m_pend;
  logic [1:0] e_move;
  bit         e_mvv, e_step, e_ovf;
  logic [2:0] e_piece;

  move_scheduler #(.DEPTH(DEPTH), .GRAVITY_TICKS(GT), .GRAVITY_CMD(GCMD)) dut (
    .game_clk(game_clk), .reset_n(reset_n), .cmd_byte(cmd_byte),
    .cmd_strobe(cmd_strobe), .tick(tick), .busy(busy),
    .move_out(move_out), .move_valid_out(move_valid_out), .piece_sel(piece_sel),
    .step_valid(step_valid), .fifo_count(fifo_count), .overflow(overflow)
  );

  always #5 game_clk = ~game_clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Behavioural model of one clock edge, from the pre-edge inputs.
  task automatic model_edge();
    bit mv, dup, real_step;
    if (!reset_n) begin
      mq.delete();
      m_grav = 0; m_pend = 0;
      e_move = 2'd0; e_mvv = 0; e_step = 0; e_piece = 3'd0; e_ovf = 0;
      return;
    end
    mv = cmd_strobe && cmd_byte[5];
    dup = 0;
`ifdef MOVE_SCHED_DEDUP_EN
    if (mv && mq.size() > 0 && mq[$] == cmd_byte[1:0]) dup = 1;
`endif
    real_step = 0;
    e_step = 0;
    if (m_pend && !busy) begin
      e_step = 1;
      m_pend = 0;
      if (mq.size() > 0) begin
        e_move = mq.pop_front(); e_mvv = 1; real_step = 1;
      end else if (m_grav == GT) begin
        e_move = GCMD; e_mvv = 1; real_step = 1;
      end else begin
        e_mvv = 0;
      end
    end else if (!m_pend && tick) begin
      m_pend = 1;
    end
    if (mv && !dup) begin
      if (mq.size() < DEPTH) mq.push_back(cmd_byte[1:0]);
      else e_ovf = 1;
    end
    if (real_step) m_grav = 0;
    else if (tick && m_grav < GT) m_grav++;
    if (cmd_strobe) e_piece = (cmd_byte[4:2] == 3'd7) ? 3'd0 : cmd_byte[4:2];
  endtask

  // One clock: model follows the edge, outputs are compared on the falling edge.
  task automatic cycle();
    @(posedge game_clk);
    model_edge();
    @(negedge game_clk);
    check_eq("step_valid", step_valid, e_step);
    check_eq("move_valid_out", move_valid_out, e_mvv);
    if (e_mvv) check_eq("move_out", move_out, e_move);
    check_eq("fifo_count", fifo_count, mq.size());
    check_eq("overflow", overflow, e_ovf);
    check_eq("piece_sel", piece_sel, e_piece);
  endtask

  task automatic idle_inputs();
    cmd_strobe = 0; tick = 0; busy = 0; cmd_byte = 8'h00;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset_n = 0;
    cycle(); cycle();
    reset_n = 1;
  endtask

  task automatic strobe(input logic [7:0] b);
    cmd_byte = b; cmd_strobe = 1;
    cycle();
    cmd_strobe = 0;
  endtask

  // Tick in one cycle, step observed in the following one.
  task automatic tick_step();
    tick = 1; cycle(); tick = 0; cycle();
  endtask

  function automatic logic [7:0] fill_byte(input int i);
`ifdef MOVE_SCHED_DEDUP_EN
    return 8'h20 | 8'(i % 4);
`else
    return 8'h20;
`endif
  endfunction

  initial begin
    @(negedge game_clk);

    // Reset
    do_reset();
    check_eq("rst_step", step_valid, 0);
    check_eq("rst_count", fifo_count, 0);
    check_eq("rst_ovf", overflow, 0);
    check_eq("rst_move", move_out, 0);
    tick_step();
    check_eq("rst_tick_step", step_valid, 1);
    check_eq("rst_tick_noop", move_valid_out, 0);

    // Queue order
    do_reset();
    strobe(8'h21); strobe(8'h23);
    check_eq("q_count", fifo_count, 2);
    tick_step();
    check_eq("q_step1", step_valid, 1);
    check_eq("q_move1", move_out, 1);
    tick_step();
    check_eq("q_move2", move_out, 3);
    check_eq("q_mvv2", move_valid_out, 1);
    tick_step();
    check_eq("q_noop", move_valid_out, 0);
    check_eq("q_noop_step", step_valid, 1);

    // Gravity
    do_reset();
    tick_step(); check_eq("g_noop1", move_valid_out, 0);
    tick_step(); check_eq("g_noop2", move_valid_out, 0);
    tick_step();
    check_eq("g_valid", move_valid_out, 1);
    check_eq("g_move", move_out, GCMD);
    tick_step(); check_eq("g_restart", move_valid_out, 0);

    // Overflow
    do_reset();
    for (int i = 0; i < 5; i++) strobe(fill_byte(i));
    check_eq("ovf_count", fifo_count, 4);
    check_eq("ovf_set", overflow, 1);
    do_reset();
    for (int i = 0; i < 4; i++) strobe(fill_byte(i));
    tick = 1; cycle(); tick = 0;
    strobe(fill_byte(0));
    check_eq("pp_step", step_valid, 1);
    check_eq("pp_count", fifo_count, 4);
    check_eq("pp_ovf", overflow, 0);

    // Busy hold-off
    busy = 1; tick = 1; cycle(); tick = 0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      check_eq("busy_nostep", step_valid, 0);
    end
    busy = 0; cycle();
    check_eq("busy_release", step_valid, 1);

    // Piece select
    strobe(8'h08); check_eq("piece2", piece_sel, 2);
    strobe(8'h1C); check_eq("piece7to0", piece_sel, 0);
    check_eq("piece_not_queued", fifo_count, 3);

    // Duplicate moves
    do_reset();
    strobe(8'h22); strobe(8'h22); strobe(8'h21);
`ifdef MOVE_SCHED_DEDUP_EN
    check_eq("dd_count", fifo_count, 2);
    tick_step(); check_eq("dd_pop1", move_out, 2);
    tick_step(); check_eq("dd_pop2", move_out, 1);
`else
    check_eq("dd_count", fifo_count, 3);
    tick_step(); check_eq("dd_pop1", move_out, 2);
    tick_step(); check_eq("dd_pop2", move_out, 2);
    tick_step(); check_eq("dd_pop3", move_out, 1);
`endif

    // Randomized traffic against the model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      reset_n    = ($urandom_range(0, 199) != 0);
      cmd_strobe = ($urandom_range(0, 9) < 4);
      cmd_byte   = 8'($urandom);
      tick       = ($urandom_range(0, 3) == 0);
      busy       = ($urandom_range(0, 9) < 3);
      cycle();
    end
    reset_n = 1;
    idle_inputs();
    cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
